// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with a valid/ready input channel and a registered
// valid/ready output channel. Single-cycle ops produce one result per clock.
// Unsigned multiply runs as a W-step shift-add sequence.
module alu_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [3:0]     op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           zero,
    output logic           carry,
    output logic           err
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  LAST_STEP = CW'(W - 1);
    localparam logic [2*W-1:0] SHR_LIMIT = (2*W)'(W);
    localparam logic [2*W-1:0] SHL_LIMIT = (2*W)'(2 * W);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_GTU  = 4'd7;
    localparam logic [3:0] OP_MULU = 4'd8;
    localparam logic [3:0] OP_LTS  = 4'd9;

    typedef enum logic {
        IDLE,
        MUL
    } state_t;

    state_t         state;
    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  count;

    logic [2*W-1:0] a_ext;
    logic [2*W-1:0] b_ext;
    logic [2*W-1:0] alu_res;
    logic           alu_carry;
    logic           alu_err;
    logic [2*W-1:0] step_acc;
    logic           accept;
    logic           drain;

    assign a_ext    = {{W{1'b0}}, a};
    assign b_ext    = {{W{1'b0}}, b};
    // A new op may enter only when idle and the output slot is free or emptying this edge.
    assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;
    assign step_acc = acc + (mplier[0] ? mcand : '0);

    // Combinational result and flags for every single-cycle opcode.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_err   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = a_ext + b_ext;
                alu_carry = alu_res[W];
            end
            OP_SUB: begin
                alu_res   = a_ext - b_ext;
                alu_carry = (a < b);
            end
            OP_AND:  alu_res = a_ext & b_ext;
            OP_OR:   alu_res = a_ext | b_ext;
            OP_XOR:  alu_res = a_ext ^ b_ext;
            OP_SHR:  alu_res = (b_ext >= SHR_LIMIT) ? '0 : (a_ext >> b);
            OP_SHL:  alu_res = (b_ext >= SHL_LIMIT) ? '0 : (a_ext << b);
            OP_GTU:  alu_res = {{(2*W-1){1'b0}}, (a > b)};
            OP_MULU: alu_res = '0;
            OP_LTS:  alu_res = {{(2*W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_err = 1'b1;
        endcase
    end

    // Control FSM, shift-add multiplier datapath and the registered output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            err       <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (op == OP_MULU)) begin
                        mcand  <= a_ext;
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        state  <= MUL;
                        if (drain) begin
                            out_valid <= 1'b0;
                        end
                    end else if (accept) begin
                        result    <= alu_res;
                        zero      <= (alu_res == '0);
                        carry     <= alu_carry;
                        err       <= alu_err;
                        out_valid <= 1'b1;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= step_acc;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        result    <= step_acc;
                        zero      <= (step_acc == '0);
                        carry     <= 1'b0;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 4-bit demo ALU. It accepts one operation per transfer on a valid/ready input channel and returns a 2W-bit result plus flags on a valid/ready output channel. Single-cycle ops sustain one result per clock. Unsigned multiply runs as a W-cycle shift-add sequence. Sits between the Tiny Tapeout I/O wrapper (or a host sequencer) and any consumer that can apply backpressure.

## Interface
- W, default 8: operand width, W >= 2; result width is 2W.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at a clock edge.
- a  in  W  operand A, unsigned.
- b  in  W  operand B, unsigned.
- op  in  4  opcode.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready at a clock edge.
- result  out  2W  result.
- zero  out  1  result == 0.
- carry  out  1  carry/borrow (see Operation).
- err  out  1  illegal opcode.

## Operation
- Opcodes (A, B zero-extended to 2W unless stated):
  - 0 ADD: A+B; carry = bit W of the sum.
  - 1 SUB: (A−B) mod 2^(2W); carry = borrow (A<B).
  - 2 AND, 3 OR, 4 XOR: bitwise, upper W bits 0.
  - 5 SHR: A>>B; 0 if B>=W.
  - 6 SHL: A<<B in 2W bits; 0 if B>=2W.
  - 7 GTU: 1 if A>B else 0.
  - 8 MULU: A*B unsigned, full 2W bits.
  - 9 LTS: 1 if signed(A) < signed(B) else 0.
  - 10–15: illegal; result 0, err=1, zero=1.
- carry=0 for all ops except ADD/SUB. err=0 for legal ops. zero is computed from the final result for every op.
- FSM states:
  - IDLE: accepting. A non-MULU op loads the output register directly. MULU loads the multiplicand, multiplier, accumulator and count=0, then moves to MUL.
  - MUL: one shift-add step per cycle, W steps. After the last step it loads the output register and returns to IDLE.
- in_ready = !rst && state==IDLE && (!out_valid || out_ready). This is combinational on out_ready.
- Output register: result/zero/carry/err/out_valid are held stable while out_valid && !out_ready.
  - out_valid clears on an output transfer unless a new result is loaded in the same edge.
  - Simultaneous output drain and input accept is legal and gives back-to-back results.
- MULU completion never finds the output register full, because MUL is only entered when the output is empty or draining that edge.

## Timing
- Reset: state=IDLE, out_valid=0, result=0, zero=0, carry=0, err=0, in_ready=0 while rst=1. Internal multiply registers are cleared.
- Reset during MUL aborts the operation; no result is produced.
- Single-cycle op accepted at edge N: out_valid=1 after edge N, with its result. Throughput is 1/cycle with out_ready=1.
- MULU accepted at edge N: in_ready=0 after edges N..N+W−1; out_valid=1 after edge N+W. The next accept is possible at edge N+W, concurrent with draining the product when out_ready=1.
- Inputs a, b, op are sampled only at the accept edge; changes at any other time are ignored.

## Test plan
- W=8, ADD a=0xFF b=0x01 → result 0x0100, carry=1, zero=0, out_valid one cycle after accept.
- SUB a=0x03 b=0x05 → result 0xFFFE, carry=1. LTS a=0x80 b=0x01 → 1. GTU a=0x80 b=0x01 → 1.
- MULU a=0xFF b=0xFF → 0xFE01 exactly 8 cycles after accept; in_ready=0 throughout. MULU a=0 b=0x37 → 0, zero=1.
- SHL a=0x81 b=4 → 0x0810. SHL b=16 → 0, zero=1. SHR a=0x80 b=8 → 0.
- Backpressure: issue ADD then XOR with out_ready=0 for 3 cycles → first result stable, in_ready=0, XOR not accepted. Raise out_ready → ADD drains, XOR is accepted the same edge, and its result appears next cycle.
- op=12 → result 0, err=1, zero=1. Assert rst at 4th MUL cycle → out_valid stays 0 and in_ready=1 the cycle after rst drops.
